// File: rtl/arm_calc_pkg.sv
// Shared constants and types for the calculator's immediate path.
// The extension unit and the immediate field encoder both use these
// ExtImm encodings, so the two stay in lock-step.
package arm_calc_pkg;

  // ExtImm format codes
  localparam logic [1:0] IMM_BYTE   = 2'b00;  // 8-bit payload, upper bits ones
  localparam logic [1:0] IMM_SEXT24 = 2'b01;  // 24-bit sign extension
  localparam logic [1:0] IMM_SEXT12 = 2'b10;  // 12-bit sign extension
  localparam logic [1:0] IMM_ZERO   = 2'b11;  // constant zero

  localparam int IMM_FIELD_W = 24;
  localparam int IMM_VALUE_W = 32;

  // Occupancy of the output register plus skid register.
  // EMPTY: nothing buffered; ONE: output register holds a beat;
  // TWO: output register and skid register both hold a beat.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_state_e;

  // One encoded beat as it travels through the buffer.
  typedef struct packed {
    logic                   fit;
    logic [IMM_FIELD_W-1:0] field;
  } imm_enc_t;

  // Forward extension, shared with the extension unit. Re-extending an
  // encoded field with this function reproduces the value exactly when fit=1.
  function automatic logic [IMM_VALUE_W-1:0] imm_extend(
    input logic [IMM_FIELD_W-1:0] field,
    input logic [1:0]             ext_imm
  );
    logic [IMM_VALUE_W-1:0] result;
    result = '0;
    case (ext_imm)
      IMM_BYTE:   result = {24'hFFFFFF, field[7:0]};
      IMM_SEXT24: result = {{8{field[23]}}, field};
      IMM_SEXT12: result = {{20{field[11]}}, field[11:0]};
      default:    result = '0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational packer: (value, ExtImm) -> (24-bit field, fit flag).
// fit says whether the dropped upper bits are exactly what the extension
// unit would regenerate from the field, i.e. whether the round trip is lossless.
module imm_fit_check
  import arm_calc_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [1:0]  i_ext_imm,
  output logic [23:0] o_field,
  output logic        o_fit
);

  // Upper-bit patterns reused by the sign-extended formats
  logic w_hi9_ones;
  logic w_hi9_zeros;
  logic w_hi21_ones;
  logic w_hi21_zeros;

  assign w_hi9_ones   = &i_value[31:23];
  assign w_hi9_zeros  = ~(|i_value[31:23]);
  assign w_hi21_ones  = &i_value[31:11];
  assign w_hi21_zeros = ~(|i_value[31:11]);

  // Select the field slice and the representability test per format
  always_comb begin
    o_field = '0;
    o_fit   = 1'b0;
    case (i_ext_imm)
      IMM_BYTE: begin
        // Byte format always re-extends with ones above bit 7
        o_field = {16'h0000, i_value[7:0]};
        o_fit   = (i_value[31:8] == 24'hFFFFFF);
      end
      IMM_SEXT24: begin
        o_field = i_value[23:0];
        o_fit   = w_hi9_ones | w_hi9_zeros;
      end
      IMM_SEXT12: begin
        o_field = {12'h000, i_value[11:0]};
        o_fit   = w_hi21_ones | w_hi21_zeros;
      end
      default: begin
        // Zero format carries no payload; only 0 is representable
        o_field = 24'h000000;
        o_fit   = (i_value == 32'h00000000);
      end
    endcase
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Immediate field encoder: packs a 32-bit value into the 24-bit instruction
// immediate field for a given ExtImm format, flags representability, and
// buffers results through a 2-entry (output + skid) valid/ready stage.
// Also keeps saturating beat/error counters and a sticky misfit flag.
//
// Handshake: a beat moves when valid && ready are both high at a rising clk
// edge. valid, once raised, stays high with payload stable until the beat
// moves; ready may toggle freely and is never derived from valid of the same
// interface. Here in_ready depends only on registered occupancy, and
// field/fit are held constant while out_valid && !out_ready.
module imm_field_encoder
  import arm_calc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      value,
  input  logic [1:0]       ExtImm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      field,
  output logic             fit,
  input  logic             clr_err,
  output logic             sticky_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Buffer state
  occ_state_e r_state;
  occ_state_e w_state_nxt;
  imm_enc_t   r_out;
  imm_enc_t   r_skid;

  // Statistics
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_sticky;

  // Datapath/handshake wires
  imm_enc_t w_enc;
  logic     w_accept;
  logic     w_deliver;
  logic     w_load_out_in;
  logic     w_load_out_skid;
  logic     w_load_skid;

  imm_fit_check u_fit_check (
    .i_value   (value),
    .i_ext_imm (ExtImm),
    .o_field   (w_enc.field),
    .o_fit     (w_enc.fit)
  );

  // Handshake qualifiers; nothing moves while reset is asserted
  assign w_accept  = in_valid  & in_ready  & ~reset;
  assign w_deliver = out_valid & out_ready & ~reset;

  // Registered-state-only status outputs
  assign out_valid  = (r_state != OCC_EMPTY);
  assign in_ready   = (r_state != OCC_TWO);
  assign field      = r_out.field;
  assign fit        = r_out.fit;
  assign sticky_err = r_sticky;
  assign enc_count  = r_enc_cnt;
  assign err_count  = r_err_cnt;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and which register loads from where (keeps FIFO order:
  // the skid entry is always older than any newly accepted beat)
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_state_nxt   = OCC_ONE;
          w_load_out_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_deliver) begin
          // Output drains this cycle, new beat replaces it directly
          w_load_out_in = 1'b1;
        end else if (w_accept) begin
          // Output held: park the new beat in the skid register
          w_state_nxt = OCC_TWO;
          w_load_skid = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a delivery can happen
        if (w_deliver) begin
          w_state_nxt     = OCC_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = OCC_EMPTY;
      end
    endcase
  end

  // Output register: holds the head beat, stable unless a load is selected
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_load_out_in) begin
      r_out <= w_enc;
    end else if (w_load_out_skid) begin
      r_out <= r_skid;
    end
  end

  // Skid register: captures a beat accepted while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid <= '0;
    end else if (w_load_skid) begin
      r_skid <= w_enc;
    end
  end

  // Saturating counters of delivered beats and delivered misfits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_deliver) begin
      if (r_enc_cnt != CNT_MAX) begin
        r_enc_cnt <= r_enc_cnt + CNT_ONE;
      end
      if (!r_out.fit && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CNT_ONE;
      end
    end
  end

  // Sticky misfit flag; a misfit delivery beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (w_deliver && !r_out.fit) begin
      r_sticky <= 1'b1;
    end else if (clr_err) begin
      r_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: directed scenarios followed by a randomized
// phase, all checked against a queue-based reference of the encoder.
module tb_imm_field_encoder;
  import arm_calc_pkg::*;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [31:0]      value     = 32'h0;
  logic [1:0]       ExtImm    = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [23:0]      field;
  logic             fit;
  logic             clr_err   = 1'b0;
  logic             sticky_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  imm_field_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .value      (value),
    .ExtImm     (ExtImm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .field      (field),
    .fit        (fit),
    .clr_err    (clr_err),
    .sticky_err (sticky_err),
    .enc_count  (enc_count),
    .err_count  (err_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Value an extension unit regenerates from a field
  function automatic logic [31:0] ref_extend(input logic [23:0] f, input logic [1:0] e);
    case (e)
      2'd0:    return {24'hFFFFFF, f[7:0]};
      2'd1:    return 32'($signed(f));
      2'd2:    return 32'($signed(f[11:0]));
      default: return 32'd0;
    endcase
  endfunction

  // Field is the low slice the format keeps; fit means the round trip is exact
  function automatic logic [24:0] ref_encode(input logic [31:0] v, input logic [1:0] e);
    logic [23:0] f;
    case (e)
      2'd0:    f = {16'h0, v[7:0]};
      2'd1:    f = v[23:0];
      2'd2:    f = {12'h0, v[11:0]};
      default: f = 24'h0;
    endcase
    return {ref_extend(f, e) == v, f};
  endfunction

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];
  logic [33:0] src_q[$];
  int          m_enc    = 0;
  int          m_err    = 0;
  logic        m_sticky = 1'b0;

  // Checks DUT against the model each cycle, then applies the coming edge
  always @(negedge clk) begin
    logic [24:0] head;
    logic [33:0] src;
    logic        dlv;
    logic        acc;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0) chk("head_fit_field", 32'({fit, field}), 32'(exp_q[0]));
    chk("enc_count", 32'(enc_count), m_enc);
    chk("err_count", 32'(err_count), m_err);
    chk("sticky_err", 32'(sticky_err), 32'(m_sticky));
    if (reset) begin
      exp_q.delete();
      src_q.delete();
      m_enc    = 0;
      m_err    = 0;
      m_sticky = 1'b0;
    end else begin
      dlv = (exp_q.size() > 0) && out_ready;
      acc = in_valid && (exp_q.size() < 2);
      if (dlv) begin
        head = exp_q.pop_front();
        src  = src_q.pop_front();
        if (fit) chk("roundtrip", ref_extend(field, src[33:32]), src[31:0]);
        m_enc = (m_enc == CNT_MAX) ? CNT_MAX : m_enc + 1;
        if (!head[24]) m_err = (m_err == CNT_MAX) ? CNT_MAX : m_err + 1;
      end
      if (dlv && !head[24]) m_sticky = 1'b1;
      else if (clr_err)     m_sticky = 1'b0;
      if (acc) begin
        exp_q.push_back(ref_encode(value, ExtImm));
        src_q.push_back({ExtImm, value});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All input changes happen 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input logic [1:0] e);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    value    = v;
    ExtImm   = e;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      budget++;
    end
    chk("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_value();
    logic [23:0] f;
    int          k;
    f = 24'($urandom);
    k = $urandom_range(0, 5);
    if (k == 0)      return $urandom;
    else if (k <= 4) return ref_extend(f, 2'(k - 1));
    else             return ref_extend(f, 2'($urandom_range(0, 3))) ^ (32'h1 << $urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic acc;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_field", 32'(field), 0);
    chk("rst_fit", 32'(fit), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();
    reset = 1'b0;

    // 1: sext24 fits, latency 1, counted on handshake
    out_ready = 1'b0;
    send(32'hFFFFF800, IMM_SEXT24);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_field", 32'(field), 32'h00FFF800);
    chk("t1_fit", 32'(fit), 1);
    chk("t1_enc_pre", 32'(enc_count), 0);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t1_enc", 32'(enc_count), 1);
    tick();

    // 2: sext12 misfit, sticky and clear
    send(32'h00000800, IMM_SEXT12);
    @(negedge clk);
    chk("t2_field", 32'(field), 32'h00000800);
    chk("t2_fit", 32'(fit), 0);
    tick();
    @(negedge clk);
    chk("t2_err", 32'(err_count), 1);
    chk("t2_sticky", 32'(sticky_err), 1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    chk("t2_sticky_clr", 32'(sticky_err), 0);
    chk("t2_err_hold", 32'(err_count), 1);
    tick();

    // 3: byte format
    send(32'hFFFFFF5A, IMM_BYTE);
    @(negedge clk);
    chk("t3a_field", 32'(field), 32'h0000005A);
    chk("t3a_fit", 32'(fit), 1);
    tick();
    send(32'h0000005A, IMM_BYTE);
    @(negedge clk);
    chk("t3b_field", 32'(field), 32'h0000005A);
    chk("t3b_fit", 32'(fit), 0);
    tick();

    // 4: backpressure with A, B, C back-to-back
    out_ready = 1'b0;
    in_valid  = 1'b1;
    value = 32'h00000012; ExtImm = IMM_BYTE;
    @(negedge clk);
    chk("t4_rdy_a", 32'(in_ready), 1);
    tick();
    value = 32'hFF800000; ExtImm = IMM_SEXT24;
    @(negedge clk);
    chk("t4_rdy_b", 32'(in_ready), 1);
    tick();
    value = 32'h000007FF; ExtImm = IMM_SEXT12;
    @(negedge clk);
    chk("t4_rdy_c", 32'(in_ready), 0);
    chk("t4_hold_a", 32'({fit, field}), 32'h00000012);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rdy_still_low", 32'(in_ready), 0);
    chk("t4_out_a", 32'({fit, field}), 32'h00000012);
    tick();
    @(negedge clk);
    chk("t4_rdy_back", 32'(in_ready), 1);
    chk("t4_out_b", 32'({fit, field}), 32'h01800000);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_out_c_valid", 32'(out_valid), 1);
    chk("t4_out_c", 32'({fit, field}), 32'h010007FF);
    tick();
    @(negedge clk);
    chk("t4_drained", 32'(out_valid), 0);
    tick();

    // 5: reset with output and skid full
    out_ready = 1'b0;
    send(32'h00000001, IMM_ZERO);
    send(32'h00000000, IMM_ZERO);
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value     = 32'h3;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_ready", 32'(in_ready), 1);
    chk("t5_enc", 32'(enc_count), 0);
    chk("t5_err", 32'(err_count), 0);
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_stale", 32'(out_valid), 0);
      tick();
    end

    // 6: random traffic, random backpressure, saturation of the counters
    acc = 1'b0;
    for (int c = 0; c < 700; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        value    = gen_value();
        ExtImm   = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_err   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
    end
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t6_drained", 32'(out_valid), 0);
    chk("t6_enc_sat", 32'(enc_count), CNT_MAX);
    chk("t6_err_model", 32'(err_count), m_err);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
